mem_wb_hist: RTL and testbench

//  Parametrised Memory/Write-Back pipeline register with stall, flush, a valid bit and an N-deep history of retired

---
 rtl/mem_wb_hist.sv | 65 ++++++
 tb/tb_mem_wb_hist.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_hist.sv
// Memory/Write-Back pipeline register with stall, flush, valid tracking and an
// N-deep shift history of retired write-back data for the forwarding unit.
module mem_wb_hist #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned LANES      = 2,
    parameter int unsigned HIST_DEPTH = 1,
    parameter int unsigned INSTR_W    = 32,
    parameter int unsigned WEN_W      = 2,
    parameter int unsigned ADDR_W     = 14
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               stall,
    input  logic                               flush,
    input  logic                               valid_in,
    input  logic [LANES*DATA_W-1:0]            data_in,
    input  logic [INSTR_W-1:0]                 instruction_in,
    input  logic [WEN_W-1:0]                   reg_file_wen_in,
    input  logic [ADDR_W-1:0]                  ret_addr_in,
    output logic                               valid_out,
    output logic [LANES*DATA_W-1:0]            data_out,
    output logic [INSTR_W-1:0]                 instruction_out,
    output logic [WEN_W-1:0]                   reg_file_wen_out,
    output logic [ADDR_W-1:0]                  ret_addr_out,
    output logic [HIST_DEPTH*LANES*DATA_W-1:0] hist_data,
    output logic [HIST_DEPTH-1:0]              hist_valid
);

    localparam int unsigned LW = LANES * DATA_W;

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_out        <= 1'b0;
            data_out         <= '0;
            instruction_out  <= '0;
            reg_file_wen_out <= '0;
            ret_addr_out     <= '0;
            hist_data        <= '0;
            hist_valid       <= '0;
        end else if (flush || !stall) begin
            // A flush still retires the current stage contents into history.
            hist_data[0 +: LW] <= data_out;
            hist_valid[0]      <= valid_out;
            for (int unsigned j = 1; j < HIST_DEPTH; j++) begin
                hist_data[j*LW +: LW] <= hist_data[(j-1)*LW +: LW];
                hist_valid[j]         <= hist_valid[j-1];
            end

            if (flush) begin
                valid_out        <= 1'b0;
                data_out         <= '0;
                instruction_out  <= '0;
                reg_file_wen_out <= '0;
                ret_addr_out     <= '0;
            end else begin
                valid_out        <= valid_in;
                data_out         <= data_in;
                instruction_out  <= instruction_in;
                reg_file_wen_out <= valid_in ? reg_file_wen_in : '0;
                ret_addr_out     <= ret_addr_in;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_hist.sv
// Directed and randomized check of mem_wb_hist (LANES=2, HIST_DEPTH=3) against
// a queue-based reference model of the stage and its retirement history.
module tb_mem_wb_hist;

    localparam int unsigned DW = 8;
    localparam int unsigned LN = 2;
    localparam int unsigned HD = 3;
    localparam int unsigned IW = 32;
    localparam int unsigned WW = 2;
    localparam int unsigned AW = 14;
    localparam int unsigned LW = LN * DW;

    logic              clock = 1'b0;
    logic              reset, stall, flush, valid_in;
    logic [LW-1:0]     data_in;
    logic [IW-1:0]     instruction_in;
    logic [WW-1:0]     reg_file_wen_in;
    logic [AW-1:0]     ret_addr_in;
    logic              valid_out;
    logic [LW-1:0]     data_out;
    logic [IW-1:0]     instruction_out;
    logic [WW-1:0]     reg_file_wen_out;
    logic [AW-1:0]     ret_addr_out;
    logic [HD*LW-1:0]  hist_data;
    logic [HD-1:0]     hist_valid;

    int n_checks = 0;
    int n_fail   = 0;

    mem_wb_hist #(
        .DATA_W(DW), .LANES(LN), .HIST_DEPTH(HD),
        .INSTR_W(IW), .WEN_W(WW), .ADDR_W(AW)
    ) dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .valid_in(valid_in), .data_in(data_in), .instruction_in(instruction_in),
        .reg_file_wen_in(reg_file_wen_in), .ret_addr_in(ret_addr_in),
        .valid_out(valid_out), .data_out(data_out), .instruction_out(instruction_out),
        .reg_file_wen_out(reg_file_wen_out), .ret_addr_out(ret_addr_out),
        .hist_data(hist_data), .hist_valid(hist_valid)
    );

    always #5 clock = ~clock;

    // Reference model: current stage contents plus a queue of retired
    // {valid, data} entries, front = most recent.
    logic          m_v;
    logic [LW-1:0] m_d;
    logic [IW-1:0] m_i;
    logic [WW-1:0] m_w;
    logic [AW-1:0] m_a;
    logic [LW:0]   m_hist[$];

    task automatic model_edge();
        if (reset) begin
            m_v = 0; m_d = '0; m_i = '0; m_w = '0; m_a = '0;
            m_hist.delete();
            for (int k = 0; k < HD; k++) m_hist.push_back('0);
        end else if (flush || !stall) begin
            m_hist.push_front({m_v, m_d});
            void'(m_hist.pop_back());
            if (flush) begin
                m_v = 0; m_d = '0; m_i = '0; m_w = '0; m_a = '0;
            end else begin
                m_v = valid_in; m_d = data_in; m_i = instruction_in;
                m_w = valid_in ? reg_file_wen_in : '0; m_a = ret_addr_in;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [HD*LW-1:0] eh;
        logic [HD-1:0]    ev;
        for (int k = 0; k < HD; k++) begin
            eh[k*LW +: LW] = m_hist[k][LW-1:0];
            ev[k]          = m_hist[k][LW];
        end
        chk("valid_out",   64'(valid_out),        64'(m_v));
        chk("data_out",    64'(data_out),         64'(m_d));
        chk("instruction", 64'(instruction_out),  64'(m_i));
        chk("wen_out",     64'(reg_file_wen_out), 64'(m_w));
        chk("ret_addr",    64'(ret_addr_out),     64'(m_a));
        chk("hist_data",   64'(hist_data),        64'(eh));
        chk("hist_valid",  64'(hist_valid),       64'(ev));
    endtask

    task automatic rand_payload();
        data_in         = LW'($urandom);
        instruction_in  = $urandom;
        reg_file_wen_in = WW'($urandom);
        ret_addr_in     = AW'($urandom);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic push(input logic [LW-1:0] d);
        rand_payload();
        valid_in = 1; data_in = d;
        step();
    endtask

    initial begin
        reset = 1; stall = 0; flush = 0; valid_in = 1;
        rand_payload();
        #2;

        // Reset with random inputs, two cycles
        for (int k = 0; k < 2; k++) begin
            rand_payload(); valid_in = 1'($urandom); stall = 1'($urandom); flush = 1'($urandom);
            step();
        end
        chk("reset_valid", 64'(valid_out), 64'(0));
        chk("reset_hist_valid", 64'(hist_valid), 64'(0));
        chk("reset_data", 64'(data_out), 64'(0));
        reset = 0; stall = 0; flush = 0;

        // Pipeline fill
        push(16'h0102); push(16'h0304); push(16'h0506); push(16'h0708);
        chk("pipe_data", 64'(data_out), 64'h0708);
        chk("pipe_hist", 64'(hist_data), 64'h0102_0304_0506);
        chk("pipe_hist_valid", 64'(hist_valid), 64'(3'b111));

        // Stall three cycles with changing inputs
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            rand_payload(); step();
            chk("stall_data", 64'(data_out), 64'h0708);
            chk("stall_hist", 64'(hist_data), 64'h0102_0304_0506);
        end
        stall = 0;
        push(16'h1112);
        chk("resume_data", 64'(data_out), 64'h1112);
        chk("resume_hist0", 64'(hist_data[LW-1:0]), 64'h0708);

        // Flush overriding stall retires current output
        push(16'h0A0B);
        stall = 1; flush = 1; rand_payload(); step();
        chk("flush_valid", 64'(valid_out), 64'(0));
        chk("flush_wen", 64'(reg_file_wen_out), 64'(0));
        chk("flush_hist0", 64'(hist_data[LW-1:0]), 64'h0A0B);
        chk("flush_hist0_valid", 64'(hist_valid[0]), 64'(1));
        stall = 0; flush = 0;

        // Write-enable gating on an invalid instruction
        rand_payload(); valid_in = 0; reg_file_wen_in = 2'b11; step();
        chk("gate_wen", 64'(reg_file_wen_out), 64'(0));
        chk("gate_valid", 64'(valid_out), 64'(0));

        // Reset mid-stream with stall and flush asserted
        for (int k = 0; k < HD + 1; k++) push(LW'($urandom));
        reset = 1; stall = 1; flush = 1; step();
        chk("rst_mid_hist", 64'(hist_data), 64'(0));
        chk("rst_mid_hist_valid", 64'(hist_valid), 64'(0));
        chk("rst_mid_valid", 64'(valid_out), 64'(0));
        reset = 0; stall = 0; flush = 0;

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            rand_payload();
            valid_in = ($urandom_range(3, 0) != 0);
            stall    = ($urandom_range(3, 0) == 0);
            flush    = ($urandom_range(7, 0) == 0);
            reset    = ($urandom_range(49, 0) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
